// File: rtl/shop_pkg.sv
// ---------------------------------------------------------------------------
// shop_pkg
// Shared types and ASCII constants for the shop command front end.
//   state_t     : dialogue FSM states
//   pend_cmd_t  : command carried from S_CMD into the username/password steps
//   CMD_KEY__*  : accepted command words (item keys reserved for the item block)
//   RSP_*       : response words
// Constants are right-justified and zero-padded in STR_BITS; users truncate
// them to their own word width with a size cast.
// ---------------------------------------------------------------------------
package shop_pkg;

    localparam int unsigned STR_BITS = 128;

    typedef enum logic [1:0] {
        S_CMD,
        S_USERNAME,
        S_PASSWORD
    } state_t;

    typedef enum logic [1:0] {
        PC_LOGIN,
        PC_ADD_USER,
        PC_DELETE_USER
    } pend_cmd_t;

    localparam logic [STR_BITS-1:0] CMD_KEY__LOGIN       = "Login";
    localparam logic [STR_BITS-1:0] CMD_KEY__LOGOUT      = "Logout";
    localparam logic [STR_BITS-1:0] CMD_KEY__ADD_USER    = "AddUsr";
    localparam logic [STR_BITS-1:0] CMD_KEY__DELETE_USER = "DelUsr";
    localparam logic [STR_BITS-1:0] CMD_KEY__ADD_ITEM    = "AddItm";
    localparam logic [STR_BITS-1:0] CMD_KEY__DELETE_ITEM = "DelItm";
    localparam logic [STR_BITS-1:0] CMD_KEY__BUY         = "Buy";

    localparam logic [STR_BITS-1:0] RSP_CMD        = "Cmd?";
    localparam logic [STR_BITS-1:0] RSP_USERNAME   = "Usrname?";
    localparam logic [STR_BITS-1:0] RSP_PASSWORD   = "Passwd?";
    localparam logic [STR_BITS-1:0] RSP_INVAL_PERM = "InvalPerm";
    localparam logic [STR_BITS-1:0] RSP_INVAL_CMD  = "InvalCmd";
    localparam logic [STR_BITS-1:0] RSP_LOGGED_OUT = "LoggedOut";
    localparam logic [STR_BITS-1:0] RSP_LOGGED_IN  = "LoggedIn";
    localparam logic [STR_BITS-1:0] RSP_BAD_PASS   = "BadPass";
    localparam logic [STR_BITS-1:0] RSP_USRS_FULL  = "UsrsFull";
    localparam logic [STR_BITS-1:0] RSP_USR_UNKNWN = "UsrUnknwn";
    localparam logic [STR_BITS-1:0] RSP_USR_TAKEN  = "UsrTaken";
    localparam logic [STR_BITS-1:0] RSP_NO_DEL_ADM = "NoDelAdmn";
    localparam logic [STR_BITS-1:0] RSP_USR_DELETD = "UsrDeletd";
    localparam logic [STR_BITS-1:0] RSP_USR_ADDED  = "UsrAdded";

endpackage

// File: rtl/shop_user_table.sv
// ---------------------------------------------------------------------------
// shop_user_table
// User table of MAX_USERS slots (name + password + valid). Slot 0 is the
// admin: loaded at reset and never written or invalidated afterwards.
//   i_clk, i_reset           : clock, async active-high reset
//   name_i / hit_o / hit_idx_o : parallel exact-match name lookup, lowest wins
//   pass_i / pass_idx_i / pass_ok_o : password compare against one slot
//   full_o / free_idx_o      : lowest invalid slot among 1..MAX_USERS-1
//   wr_en_i / wr_idx_i / wr_name_i / wr_pass_i : fill a slot
//   inv_en_i / inv_idx_i     : invalidate and zero a slot
// ---------------------------------------------------------------------------
module shop_user_table #(
    parameter int unsigned    W          = 56,
    parameter int unsigned    MAX_USERS  = 5,
    parameter int unsigned    UIDX_BITS  = 4,
    parameter logic [W-1:0]   ADMIN_NAME = '0,
    parameter logic [W-1:0]   ADMIN_PASS = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [W-1:0]         name_i,
    output logic                 hit_o,
    output logic [UIDX_BITS-1:0] hit_idx_o,
    input  logic [W-1:0]         pass_i,
    input  logic [UIDX_BITS-1:0] pass_idx_i,
    output logic                 pass_ok_o,
    output logic                 full_o,
    output logic [UIDX_BITS-1:0] free_idx_o,
    input  logic                 wr_en_i,
    input  logic [UIDX_BITS-1:0] wr_idx_i,
    input  logic [W-1:0]         wr_name_i,
    input  logic [W-1:0]         wr_pass_i,
    input  logic                 inv_en_i,
    input  logic [UIDX_BITS-1:0] inv_idx_i
);

    logic [W-1:0] name_q  [MAX_USERS];
    logic [W-1:0] pass_q  [MAX_USERS];
    logic         valid_q [MAX_USERS];

    // Writes loop from 1 so slot 0 keeps its reset contents.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < MAX_USERS; i++) begin
                valid_q[i] <= (i == 0);
                name_q[i]  <= (i == 0) ? ADMIN_NAME : '0;
                pass_q[i]  <= (i == 0) ? ADMIN_PASS : '0;
            end
        end else begin
            for (int unsigned i = 1; i < MAX_USERS; i++) begin
                if (wr_en_i && (wr_idx_i == UIDX_BITS'(i))) begin
                    valid_q[i] <= 1'b1;
                    name_q[i]  <= wr_name_i;
                    pass_q[i]  <= wr_pass_i;
                end else if (inv_en_i && (inv_idx_i == UIDX_BITS'(i))) begin
                    valid_q[i] <= 1'b0;
                    name_q[i]  <= '0;
                    pass_q[i]  <= '0;
                end
            end
        end
    end

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int unsigned i = 0; i < MAX_USERS; i++) begin
            if (!hit_o && valid_q[i] && (name_q[i] == name_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = UIDX_BITS'(i);
            end
        end
    end

    always_comb begin
        pass_ok_o = 1'b0;
        for (int unsigned i = 0; i < MAX_USERS; i++) begin
            if (pass_idx_i == UIDX_BITS'(i)) begin
                pass_ok_o = valid_q[i] && (pass_q[i] == pass_i);
            end
        end
    end

    always_comb begin
        full_o     = 1'b1;
        free_idx_o = '0;
        for (int unsigned i = 1; i < MAX_USERS; i++) begin
            if (full_o && !valid_q[i]) begin
                full_o     = 1'b0;
                free_idx_o = UIDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/shop_user_mgr.sv
// ---------------------------------------------------------------------------
// shop_user_mgr
// Login / Logout / AddUsr / DelUsr dialogue over a user table, one registered
// ASCII response per accepted input word.
//   i_clk, i_reset : clock, async active-high reset
//   i_rdy, i_a     : input word strobe and right-justified zero-padded word
//   o_a, o_vld     : response word (held between responses) and its strobe
//   o_logged_in, o_user_idx, o_is_admin : current login state
// ---------------------------------------------------------------------------
module shop_user_mgr
    import shop_pkg::*;
#(
    parameter int unsigned I_A_NUM_ASCII_CHARS = 7,
    parameter int unsigned O_A_NUM_ASCII_CHARS = 9,
    parameter int unsigned MAX_USERS           = 5,
    parameter int unsigned UIDX_BITS           = 4,
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_USERNAME = "Adm",
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_PASSWORD = "AdmPw"
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rdy,
    input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a,
    output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a,
    output logic                             o_vld,
    output logic                             o_logged_in,
    output logic [UIDX_BITS-1:0]             o_user_idx,
    output logic                             o_is_admin
);

    localparam int unsigned IW = I_A_NUM_ASCII_CHARS * 8;
    localparam int unsigned OW = O_A_NUM_ASCII_CHARS * 8;

    state_t                state_q;
    pend_cmd_t             pend_q;
    logic [IW-1:0]         uname_q;
    logic [UIDX_BITS-1:0]  slot_q;
    logic [OW-1:0]         a_q;
    logic                  vld_q;
    logic                  logged_q;
    logic [UIDX_BITS-1:0]  uidx_q;
    logic                  admin_q;

    logic                  hit;
    logic [UIDX_BITS-1:0]  hit_idx;
    logic                  pass_ok;
    logic                  full;
    logic [UIDX_BITS-1:0]  free_idx;
    logic                  wr_en;
    logic                  inv_en;

    // Table updates share the clock edge with the FSM transition that
    // produces the matching response.
    assign wr_en  = i_rdy && (state_q == S_PASSWORD) && (pend_q == PC_ADD_USER);
    assign inv_en = i_rdy && (state_q == S_USERNAME) && (pend_q == PC_DELETE_USER)
                    && hit && (hit_idx != '0);

    shop_user_table #(
        .W          (IW),
        .MAX_USERS  (MAX_USERS),
        .UIDX_BITS  (UIDX_BITS),
        .ADMIN_NAME (ADMIN_USERNAME),
        .ADMIN_PASS (ADMIN_PASSWORD)
    ) u_table (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .name_i     (i_a),
        .hit_o      (hit),
        .hit_idx_o  (hit_idx),
        .pass_i     (i_a),
        .pass_idx_i (slot_q),
        .pass_ok_o  (pass_ok),
        .full_o     (full),
        .free_idx_o (free_idx),
        .wr_en_i    (wr_en),
        .wr_idx_i   (free_idx),
        .wr_name_i  (uname_q),
        .wr_pass_i  (i_a),
        .inv_en_i   (inv_en),
        .inv_idx_i  (hit_idx)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_CMD;
            pend_q   <= PC_LOGIN;
            uname_q  <= '0;
            slot_q   <= '0;
            a_q      <= OW'(RSP_CMD);
            vld_q    <= 1'b0;
            logged_q <= 1'b0;
            uidx_q   <= '0;
            admin_q  <= 1'b0;
        end else begin
            vld_q <= i_rdy;
            if (i_rdy) begin
                case (state_q)
                    S_CMD: begin
                        if (i_a == IW'(CMD_KEY__LOGIN)) begin
                            if (!logged_q) begin
                                state_q <= S_USERNAME;
                                pend_q  <= PC_LOGIN;
                                a_q     <= OW'(RSP_USERNAME);
                            end else begin
                                a_q     <= OW'(RSP_INVAL_PERM);
                            end
                        end else if (i_a == IW'(CMD_KEY__LOGOUT)) begin
                            if (logged_q) begin
                                logged_q <= 1'b0;
                                uidx_q   <= '0;
                                admin_q  <= 1'b0;
                                a_q      <= OW'(RSP_LOGGED_OUT);
                            end else begin
                                a_q      <= OW'(RSP_INVAL_PERM);
                            end
                        end else if (i_a == IW'(CMD_KEY__ADD_USER)) begin
                            if (!admin_q) begin
                                a_q     <= OW'(RSP_INVAL_PERM);
                            end else if (full) begin
                                a_q     <= OW'(RSP_USRS_FULL);
                            end else begin
                                state_q <= S_USERNAME;
                                pend_q  <= PC_ADD_USER;
                                a_q     <= OW'(RSP_USERNAME);
                            end
                        end else if (i_a == IW'(CMD_KEY__DELETE_USER)) begin
                            if (!admin_q) begin
                                a_q     <= OW'(RSP_INVAL_PERM);
                            end else begin
                                state_q <= S_USERNAME;
                                pend_q  <= PC_DELETE_USER;
                                a_q     <= OW'(RSP_USERNAME);
                            end
                        end else begin
                            a_q <= OW'(RSP_INVAL_CMD);
                        end
                    end

                    S_USERNAME: begin
                        uname_q <= i_a;
                        case (pend_q)
                            PC_LOGIN: begin
                                if (hit) begin
                                    slot_q  <= hit_idx;
                                    state_q <= S_PASSWORD;
                                    a_q     <= OW'(RSP_PASSWORD);
                                end else begin
                                    state_q <= S_CMD;
                                    a_q     <= OW'(RSP_USR_UNKNWN);
                                end
                            end
                            PC_ADD_USER: begin
                                if (hit) begin
                                    state_q <= S_CMD;
                                    a_q     <= OW'(RSP_USR_TAKEN);
                                end else begin
                                    state_q <= S_PASSWORD;
                                    a_q     <= OW'(RSP_PASSWORD);
                                end
                            end
                            default: begin
                                // Delete: the table invalidates via inv_en.
                                state_q <= S_CMD;
                                if (hit && (hit_idx == '0)) begin
                                    a_q <= OW'(RSP_NO_DEL_ADM);
                                end else if (!hit) begin
                                    a_q <= OW'(RSP_USR_UNKNWN);
                                end else begin
                                    a_q <= OW'(RSP_USR_DELETD);
                                end
                            end
                        endcase
                    end

                    S_PASSWORD: begin
                        state_q <= S_CMD;
                        if (pend_q == PC_LOGIN) begin
                            if (pass_ok) begin
                                logged_q <= 1'b1;
                                uidx_q   <= slot_q;
                                admin_q  <= (slot_q == '0);
                                a_q      <= OW'(RSP_LOGGED_IN);
                            end else begin
                                a_q      <= OW'(RSP_BAD_PASS);
                            end
                        end else if (pend_q == PC_ADD_USER) begin
                            a_q <= OW'(RSP_USR_ADDED);
                        end else begin
                            a_q <= OW'(RSP_INVAL_CMD);
                        end
                    end

                    default: state_q <= S_CMD;
                endcase
            end
        end
    end

    assign o_a         = a_q;
    assign o_vld       = vld_q;
    assign o_logged_in = logged_q;
    assign o_user_idx  = uidx_q;
    assign o_is_admin  = admin_q;

endmodule

// File: tb/tb_shop_user_mgr.sv
// ---------------------------------------------------------------------------
// tb_shop_user_mgr
// Directed bench for shop_user_mgr with hand-computed responses.
// ---------------------------------------------------------------------------
module tb_shop_user_mgr;

    logic        clk;
    logic        i_reset;
    logic        i_rdy;
    logic [55:0] i_a;
    logic [71:0] o_a;
    logic        o_vld;
    logic        o_logged_in;
    logic [3:0]  o_user_idx;
    logic        o_is_admin;

    int unsigned errors = 0;
    int unsigned checks = 0;

    shop_user_mgr #(
        .I_A_NUM_ASCII_CHARS (7),
        .O_A_NUM_ASCII_CHARS (9),
        .MAX_USERS           (5),
        .UIDX_BITS           (4),
        .ADMIN_USERNAME      ("Adm"),
        .ADMIN_PASSWORD      ("AdmPw")
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rdy       (i_rdy),
        .i_a         (i_a),
        .o_a         (o_a),
        .o_vld       (o_vld),
        .o_logged_in (o_logged_in),
        .o_user_idx  (o_user_idx),
        .o_is_admin  (o_is_admin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One word in, response checked one cycle later.
    task automatic send(input logic [55:0] w, input logic [71:0] exp, input string tag);
        @(negedge clk);
        i_a   = w;
        i_rdy = 1'b1;
        @(posedge clk);
        #1;
        i_rdy = 1'b0;
        chk({tag, "_vld"}, 72'(o_vld), 72'd1);
        chk(tag, o_a, exp);
    endtask

    // Idle cycle: no strobe, response held.
    task automatic idle(input logic [71:0] hold, input string tag);
        @(negedge clk);
        i_a = '0;
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 72'(o_vld), 72'd0);
        chk(tag, o_a, hold);
    endtask

    task automatic chk_login(input logic li, input logic [3:0] idx, input logic adm, input string tag);
        chk({tag, "_li"},  72'(o_logged_in), 72'(li));
        chk({tag, "_idx"}, 72'(o_user_idx),  72'(idx));
        chk({tag, "_adm"}, 72'(o_is_admin),  72'(adm));
    endtask

    initial begin
        i_reset = 1'b1;
        i_rdy   = 1'b0;
        i_a     = '0;
        #1;
        chk("rst_a", o_a, "Cmd?");
        chk("rst_vld", 72'(o_vld), 72'd0);
        chk_login(1'b0, 4'd0, 1'b0, "rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;

        // Admin login
        send("Login", "Usrname?", "adm_login");
        send("Adm",   "Passwd?",  "adm_user");
        send("AdmPw", "LoggedIn", "adm_pass");
        chk_login(1'b1, 4'd0, 1'b1, "adm");

        // Add bob into slot 1, then duplicate
        send("AddUsr", "Usrname?", "add_bob_cmd");
        send("bob",    "Passwd?",  "add_bob_user");
        send("pw1",    "UsrAdded", "add_bob_pass");
        send("AddUsr", "Usrname?", "dup_bob_cmd");
        send("bob",    "UsrTaken", "dup_bob_user");
        send("Xyz",    "InvalCmd", "dup_back_in_cmd");
        send("AddUsr", "Usrname?", "dup_adm_cmd");
        send("Adm",    "UsrTaken", "dup_adm_user");

        // Fill slots 2..4
        send("AddUsr", "Usrname?", "add_u2_cmd");
        send("u2",     "Passwd?",  "add_u2_user");
        send("p",      "UsrAdded", "add_u2_pass");
        send("AddUsr", "Usrname?", "add_u3_cmd");
        send("u3",     "Passwd?",  "add_u3_user");
        send("p",      "UsrAdded", "add_u3_pass");
        send("AddUsr", "Usrname?", "add_u4_cmd");
        send("u4",     "Passwd?",  "add_u4_user");
        send("p",      "UsrAdded", "add_u4_pass");
        send("AddUsr", "UsrsFull", "full");

        // Deletes
        send("DelUsr", "Usrname?",  "del_adm_cmd");
        send("Adm",    "NoDelAdmn", "del_adm_user");
        send("DelUsr", "Usrname?",  "del_zz_cmd");
        send("zz",     "UsrUnknwn", "del_zz_user");
        send("DelUsr", "Usrname?",  "del_u2_cmd");
        send("u2",     "UsrDeletd", "del_u2_user");
        send("AddUsr", "Usrname?",  "add_eve_cmd");
        send("eve",    "Passwd?",   "add_eve_user");
        send("x",      "UsrAdded",  "add_eve_pass");
        idle("UsrAdded", "hold_after_eve");
        send("AddUsr", "UsrsFull",  "full_again");

        // Logout; bob with bad then good password
        send("Logout", "LoggedOut", "adm_logout");
        chk_login(1'b0, 4'd0, 1'b0, "after_logout");
        send("Login",  "Usrname?",  "bob_bad_cmd");
        send("bob",    "Passwd?",   "bob_bad_user");
        send("bad",    "BadPass",   "bob_bad_pass");
        chk_login(1'b0, 4'd0, 1'b0, "bob_bad");
        send("Login",  "Usrname?",  "bob_cmd");
        send("bob",    "Passwd?",   "bob_user");
        send("pw1",    "LoggedIn",  "bob_pass");
        chk_login(1'b1, 4'd1, 1'b0, "bob");
        send("AddUsr", "InvalPerm", "bob_add");
        send("DelUsr", "InvalPerm", "bob_del");
        send("Login",  "InvalPerm", "bob_relogin");
        send("Xyz",    "InvalCmd",  "bob_xyz");
        send("Logout", "LoggedOut", "bob_logout");

        // Logged out errors, padding significance
        send("Logout", "InvalPerm", "out_logout");
        send("Login",  "Usrname?",  "zed_cmd");
        send("zed",    "UsrUnknwn", "zed_user");
        send("Login",  "Usrname?",  "sp_bob_cmd");
        send(" bob",   "UsrUnknwn", "sp_bob_user");
        send("Login",  "Usrname?",  "u2_cmd");
        send("u2",     "UsrUnknwn", "u2_deleted");

        // eve sits in the slot freed by u2
        send("Login",  "Usrname?",  "eve_cmd");
        send("eve",    "Passwd?",   "eve_user");
        send("x",      "LoggedIn",  "eve_pass");
        chk_login(1'b1, 4'd2, 1'b0, "eve");
        send("Logout", "LoggedOut", "eve_logout");

        // Back-to-back strobes
        idle("LoggedOut", "b2b_pre");
        send("Logout", "InvalPerm", "b2b_0");
        send("Xyz",    "InvalCmd",  "b2b_1");
        send("Logout", "InvalPerm", "b2b_2");
        idle("InvalPerm", "b2b_post");

        // Reset between username and password
        send("Login", "Usrname?", "mid_cmd");
        send("bob",   "Passwd?",  "mid_user");
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        chk("mid_rst_a", o_a, "Cmd?");
        chk("mid_rst_vld", 72'(o_vld), 72'd0);
        chk_login(1'b0, 4'd0, 1'b0, "mid_rst");
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        send("pw1",   "InvalCmd",  "post_rst_pw");
        send("Login", "Usrname?",  "post_rst_cmd");
        send("bob",   "UsrUnknwn", "post_rst_bob");
        send("Login", "Usrname?",  "post_rst_adm_cmd");
        send("Adm",   "Passwd?",   "post_rst_adm_user");
        send("AdmPw", "LoggedIn",  "post_rst_adm_pass");
        chk_login(1'b1, 4'd0, 1'b1, "post_rst_adm");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shop_user_mgr.md
Name: shop_user_mgr

Overview:
- Parametrised successor to the single-state shop command front end.
- Holds a real user table of MAX_USERS slots: username and password, with slot 0 hard-wired to the admin.
- Runs the Login / Logout / AddUsr / DelUsr dialogue as a three-state FSM and tracks the logged-in user.
- Emits one registered ASCII response per accepted input word; sits between the character-input front end and the later item/stock block, which consumes o_logged_in / o_user_idx.

Parameters:
- I_A_NUM_ASCII_CHARS, 7, input word width in chars; must fit the longest command key, username or password.
- O_A_NUM_ASCII_CHARS, 9, output word width in chars; must fit the longest response.
- MAX_USERS, 5, table slots including admin; range 2..15.
- UIDX_BITS, 4, width of the user index; must satisfy 2**UIDX_BITS >= MAX_USERS.
- ADMIN_USERNAME, "Adm", slot 0 name.
- ADMIN_PASSWORD, "AdmPw", slot 0 password.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_rdy  in  1  one-cycle strobe: i_a holds a valid word
- i_a  in  I_A_NUM_ASCII_CHARS*8  ASCII word, right-justified, zero-padded
- o_a  out  O_A_NUM_ASCII_CHARS*8  ASCII response, right-justified, zero-padded
- o_vld  out  1  one-cycle strobe: o_a is new
- o_logged_in  out  1  a user is logged in
- o_user_idx  out  UIDX_BITS  slot of the logged-in user; 0 when logged out
- o_is_admin  out  1  logged-in user is slot 0

Behaviour:
- Reset: i_reset, asynchronous, active-high; clock i_clk.
- Reset values:
  - FSM in S_CMD; o_a = "Cmd?"; o_vld = 0; o_logged_in = 0; o_user_idx = 0; o_is_admin = 0.
  - Slot 0 valid with ADMIN_USERNAME / ADMIN_PASSWORD; slots 1..MAX_USERS-1 invalid and zeroed.
  - Reset mid-dialogue discards the pending command and any partial username.
- Timing:
  - Every i_rdy cycle is processed; cycles with i_rdy=0 change nothing.
  - The response appears on o_a with o_vld=1 exactly one cycle after the i_rdy cycle.
  - Back-to-back i_rdy gives back-to-back responses.
  - o_a holds its value between responses.
- FSM states S_CMD, S_USERNAME, S_PASSWORD.
- S_CMD, per i_a value:
  - Login: if logged out -> S_USERNAME, "Usrname?"; else stay, "InvalPerm".
  - Logout: if logged in -> clear login, "LoggedOut"; else "InvalPerm".
  - AddUsr: if not admin -> "InvalPerm"; else if no free slot -> "UsrsFull"; else -> S_USERNAME, "Usrname?".
  - DelUsr: if not admin -> "InvalPerm"; else -> S_USERNAME, "Usrname?".
  - Any other word -> "InvalCmd"; stay in S_CMD.
- S_USERNAME, latch the pending command and username:
  - Login: if known -> S_PASSWORD, "Passwd?"; else -> S_CMD, "UsrUnknwn".
  - AddUsr: if already present -> S_CMD, "UsrTaken"; else -> S_PASSWORD, "Passwd?".
  - DelUsr: if i_a matches slot 0 -> S_CMD, "NoDelAdmn"; else if unknown -> S_CMD, "UsrUnknwn"; else invalidate and zero the slot -> S_CMD, "UsrDeletd".
- S_PASSWORD:
  - Login: on match, set o_logged_in, o_user_idx = slot, o_is_admin = (slot==0), response "LoggedIn"; on mismatch, "BadPass". Either way -> S_CMD.
  - AddUsr: write name and password into the lowest-index free slot -> S_CMD, "UsrAdded".
- Matching is a full-width exact compare against valid slots only. Zero-padding is significant, so "ab" differs from " ab".
- Lookup is combinational and parallel over all slots. When more than one slot matches, the lowest index wins; this cannot occur after AddUsr's uniqueness check.
- The free slot is searched at AddUsr acceptance and again at the password write. The table cannot change in between.
- The logged-in user is always admin when DelUsr runs, and admin cannot be deleted, so login state never references an invalid slot.

Decomposition:
- Package shop_pkg:
  - state encodings S_CMD / S_USERNAME / S_PASSWORD.
  - Command-key constants: CMD_KEY__LOGIN, __LOGOUT, __ADD_USER, __DELETE_USER, plus __ADD_ITEM, __DELETE_ITEM and __BUY reserved for the item block.
  - All response string constants.
- Sub-module shop_user_table:
  - storage for the slots.
  - parallel name lookup outputs: hit, hit_idx.
  - password compare.
  - lowest-free-slot encoder outputs: full, free_idx.
  - write and invalidate ports.
- The top level holds the FSM, the pending-command register and the output register.

Test Plan:
- Reset, then Login/"Adm"/"AdmPw" -> responses "Usrname?", "Passwd?", "LoggedIn"; o_is_admin=1, o_user_idx=0.
- As admin, AddUsr/"bob"/"pw1", then AddUsr/"bob" -> "UsrAdded" into slot 1; second attempt gives "UsrTaken", FSM back in S_CMD.
- As admin, fill slots 1..4, then AddUsr -> "UsrsFull". Then DelUsr/"Adm" -> "NoDelAdmn". Then DelUsr/"u2" -> "UsrDeletd". AddUsr/"eve"/"x" lands in slot 2.
- Logout, Login/"bob"/"bad" -> "BadPass", logged out. Login/"bob"/"pw1" -> "LoggedIn", o_user_idx=1. AddUsr -> "InvalPerm". "Xyz" -> "InvalCmd".
- Logged out: Logout -> "InvalPerm"; Login/"zed" -> "UsrUnknwn". Back-to-back i_rdy gives an o_vld pulse every cycle, one cycle late.
- Assert i_reset between Login and the password word -> "Cmd?", logged out, slot 1 invalid. A subsequent Login/"bob" -> "UsrUnknwn".
